// File: rtl/ones_accumulator.sv
// ones_accumulator
//   Frame-level ones counter. Every accepted input beat adds the popcount of
//   its word into a running accumulator. When the beat flagged in_last is
//   accepted, the frame total and its overflow flag are latched and offered
//   on a valid/ready output. The accumulator is cleared for the next frame.
//
// Parameters
//   A_size    accumulator / result width (default 8)
//   B_size    input word width, 2..64 (default 8)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (state ACC)
//   in_data    word whose set bits are counted
//   in_last    beat is the final beat of its frame
//   out_valid  frame result valid (state HOLD)
//   out_ready  consumer accepts the result
//   out_sum    frame ones total
//   out_ovf    frame total exceeded 2^A_size-1
//
// Build option
//   ONES_ACC_SATURATE_EN  defined: clamp the accumulator at 2^A_size-1 once
//                         it overflows. Undefined: wrap modulo 2^A_size.

module ones_accumulator #(
    parameter int A_size = 8,
    parameter int B_size = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [B_size-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [A_size-1:0] out_sum,
    output logic              out_ovf
);

    // Width of the per-word popcount, and of the sum it is added into.
    // With the default sizes the sum is exactly A_size+1 bits; the max()
    // keeps overflow detection exact if the word's popcount alone is wider
    // than the accumulator.
    localparam int CW = $clog2(B_size + 1);
    localparam int SW = ((A_size > CW) ? A_size : CW) + 1;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [A_size-1:0] acc;
    logic              ovf;

    logic [CW-1:0]     pop;
    logic [SW-1:0]     nxt;
    logic              evt;
    logic              fovf;
    logic [A_size-1:0] val;
    logic              accept;

    // Popcount as a ripple of single-bit increments.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < B_size; i++) begin
            pop = pop + CW'(in_data[i]);
        end
    end

    always_comb begin
        nxt  = SW'(acc) + SW'(pop);
        evt  = |nxt[SW-1:A_size];
        fovf = ovf | evt;
`ifdef ONES_ACC_SATURATE_EN
        // Once the frame has overflowed, the accumulator pins at all-ones.
        val  = fovf ? '1 : nxt[A_size-1:0];
`else
        val  = nxt[A_size-1:0];
`endif
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && (state == ACC);

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (accept && in_last) state_nxt = HOLD;
            HOLD:    if (out_ready)         state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACC;
            acc     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (in_last) begin
                    out_sum <= val;
                    out_ovf <= fovf;
                    acc     <= '0;
                    ovf     <= 1'b0;
                end else begin
                    acc <= val;
                    ovf <= fovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_ones_accumulator.sv
// Self-checking bench for ones_accumulator (A_size=8, B_size=8).
// Expected frame results come from a behavioural model and are queued when
// the last beat is accepted; they are popped when the result is taken.
// Honours ONES_ACC_SATURATE_EN the same way the design does.

module tb_ones_accumulator;

    localparam int A   = 8;
    localparam int B   = 8;
    localparam int MAX = (1 << A) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [B-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [A-1:0] out_sum;
    logic         out_ovf;

    ones_accumulator #(.A_size(A), .B_size(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   macc        = 0;
    int   movf        = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model of one accepted beat.
    task automatic model_beat(input logic [B-1:0] d, input bit last);
        int   s;
        int   fovf;
        int   v;
        exp_t e;
        s    = macc + $countones(d);
        fovf = (movf != 0 || s > MAX) ? 1 : 0;
`ifdef ONES_ACC_SATURATE_EN
        v    = (fovf != 0) ? MAX : (s % (MAX + 1));
`else
        v    = s % (MAX + 1);
`endif
        if (last) begin
            e.sum = v;
            e.ovf = fovf;
            sb.push_back(e);
            macc = 0;
            movf = 0;
        end else begin
            macc = v;
            movf = fovf;
        end
    endtask

    // Drive one beat; returns #1 after the accepting edge. With hold=1,
    // in_valid stays high so the caller can chain beats without gaps.
    task automatic send_beat(input logic [B-1:0] d, input bit last, input bit hold,
                             output int acc_cyc);
        bit done;
        done     = 0;
        acc_cyc  = -1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_beat(d, last);
                acc_cyc = cyc;
                done    = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("beat_timeout", in_ready, 1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        macc  = 0;
        movf  = 0;
        sb.delete();
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Result monitor: compare at each output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", out_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_sum", out_sum, e.sum);
                check("out_ovf", out_ovf, e.ovf);
            end
        end
    end

    initial begin
        int c;
        int prev_last;
        int len;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single-beat frame, latency and HOLD outputs.
        send_beat(8'hFF, 1, 0, c);
        check("t1_out_valid", out_valid, 1);
        check("t1_in_ready", in_ready, 0);
        check("t1_out_sum", out_sum, 8);
        check("t1_out_ovf", out_ovf, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t1_in_ready_back", in_ready, 1);

        // Three-beat frame with out_ready tied high: out_valid for one cycle.
        send_beat(8'h01, 0, 0, c);
        send_beat(8'h00, 0, 0, c);
        send_beat(8'hF0, 1, 0, c);
        check("t2_valid_hi", out_valid, 1);
        @(posedge clk);
        #1;
        check("t2_valid_lo", out_valid, 0);
        check("t2_in_ready", in_ready, 1);
        check("t2_sum_held", out_sum, 5);

        // Backpressure: result held, input blocked.
        out_ready = 1'b0;
        send_beat(8'hFF, 0, 0, c);
        send_beat(8'h0F, 1, 0, c);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_sum", out_sum, 12);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Overflow: 33 x 8'hFF = 264 ones.
        for (int i = 0; i < 33; i++) send_beat(8'hFF, i == 32, 0, c);
`ifdef ONES_ACC_SATURATE_EN
        check("ovf_sum", out_sum, 255);
`else
        check("ovf_sum", out_sum, 8);
`endif
        check("ovf_flag", out_ovf, 1);
        @(posedge clk);
        #1;

        // Reset mid-frame discards partial accumulation.
        send_beat(8'h0F, 0, 0, c);
        send_beat(8'h0F, 0, 0, c);
        do_reset();
        send_beat(8'h03, 1, 0, c);
        check("abort_sum", out_sum, 2);
        check("abort_ovf", out_ovf, 0);
        @(posedge clk);
        #1;

        // Reset in HOLD drops the pending result.
        out_ready = 1'b0;
        send_beat(8'h07, 1, 0, c);
        check("hold_valid", out_valid, 1);
        do_reset();
        out_ready = 1'b1;
        send_beat(8'h03, 1, 0, c);
        @(posedge clk);
        #1;

        // Back-to-back frames, in_valid and out_ready always high.
        prev_last = -1;
        for (int f = 0; f < 5; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                send_beat(B'($urandom), b == len - 1, 1, c);
                if (b == 0 && prev_last >= 0) check("b2b_gap", c - prev_last, 2);
                if (b == len - 1) prev_last = c;
            end
        end
        in_valid = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ones_accumulator.md
# ones_accumulator

Frame-level ones counter for the population-count datapath. Each handshaked input beat carries a `B_size`-bit word; its popcount, computed as a ripple of single-bit increments into the running total, is added to an `A_size`-bit accumulator. When the beat flagged `in_last` is accepted, the frame total is latched and presented on a valid/ready output. The block sits directly downstream of the combinational word-sum stage and turns its per-word results into per-frame results.

## Interface
- `A_size`, default 8: accumulator and result width.
- `B_size`, default 8: input word width, 2..64.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  B_size  word whose set bits are counted.
- `in_last`  in  1  beat is the final beat of its frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  A_size  frame ones total.
- `out_ovf`  out  1  frame total exceeded 2^A_size-1.

## Operation
- States: ACC and HOLD. Reset enters ACC with `acc`=0, `ovf`=0, `out_sum`=0, `out_valid`=0, `out_ovf`=0.
- ACC: `in_ready`=1 and `out_valid`=0. A beat is accepted when `in_valid`=1.
  - `nxt = acc + popcount(in_data)`, evaluated at A_size+1 bits.
  - `nxt[A_size]`=1 counts as an overflow event. The frame overflow flag is `fovf = ovf | event`.
  - Not last: `acc <= nxt[A_size-1:0]`, or the clamped value (see Configuration); `ovf <= fovf`.
  - Last: `out_sum <= ` the same value; `out_ovf <= fovf`; `acc <= 0`; `ovf <= 0`; next state HOLD.
- HOLD: `in_ready`=0 and `out_valid`=1. `out_sum` and `out_ovf` stay stable until `out_ready`=1, then the next state is ACC.
- A single-beat frame (`in_last` set on the first beat) is legal.
- An all-zero word adds 0 but still counts as a beat.
- `in_data` and `in_last` are ignored whenever `in_valid`=0 or `in_ready`=0.
- `out_sum` and `out_ovf` hold their last values after the result is taken, until the next frame completes.

## Timing
- All outputs are registered. `in_ready` and `out_valid` are decoded from the state register only.
- Latency: `out_valid` rises on the cycle after the `in_last` beat is accepted.
- Throughput: one beat per cycle within a frame. There is one bubble per frame boundary: HOLD lasts at least 1 cycle, and input is blocked while in HOLD.
- Returning to ACC after `out_ready`: the next beat can be accepted on the following cycle.
- Reset mid-frame or in HOLD:
  - Partial accumulation is discarded and a pending result is dropped.
  - All outputs go to their reset values immediately, asynchronously.
  - Reset release is synchronised externally by the system.
- `out_ready` asserted while in ACC has no effect.

## Configuration
- `ONES_ACC_SATURATE_EN` defined: on an overflow event the accumulator clamps to 2^A_size-1 and stays there for the rest of the frame. `out_sum` is then 2^A_size-1 and `out_ovf`=1.
- Not defined: the accumulator wraps modulo 2^A_size and `out_sum` is the true total mod 2^A_size. `out_ovf` is still reported.

## Test plan
- Reset, then a single beat `in_data`=8'hFF with `in_last`=1 -> one cycle later `out_valid`=1, `out_sum`=8, `out_ovf`=0, `in_ready`=0.
- Frame of 3 beats (8'h01, 8'h00, 8'hF0 last) with `out_ready` tied 1 -> `out_sum`=5. `out_valid` is high for exactly 1 cycle and `in_ready` returns to 1 the cycle after.
- Backpressure: frame total 12, `out_ready` held 0 for 10 cycles -> `out_valid` stays 1, `out_sum`=12 is stable, and `in_valid` beats are not accepted (`in_ready`=0).
- Overflow, A_size=8, 33 beats of 8'hFF -> without the macro: `out_sum`=8 (264 mod 256), `out_ovf`=1. With `ONES_ACC_SATURATE_EN`: `out_sum`=255, `out_ovf`=1.
- Assert `rst_n`=0 after 2 beats of 8'h0F, then release and send one beat 8'h03 with `in_last`=1 -> `out_sum`=2, `out_ovf`=0. Nothing from the aborted frame leaks into the result.
- Back-to-back frames with `in_valid` always 1 and `out_ready` always 1 -> the first beat of frame 2 is accepted 2 cycles after the last beat of frame 1. Each result matches its frame and frame 2 starts with `acc`=0.
